// File: rtl/commit_unit.sv
// rtl/commit_unit.sv - ROB retire consumer: PRF write-back, freed-preg FIFO, commit counter
`ifndef RETIRE_WIDTH
`define RETIRE_WIDTH 45
`endif

module commit_unit #(
    parameter int FREE_Q_DEPTH = 8,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [`RETIRE_WIDTH-1:0] retire0,
    input  logic [`RETIRE_WIDTH-1:0] retire1,
    output logic                     prf_we0,
    output logic [5:0]               prf_waddr0,
    output logic [31:0]              prf_wdata0,
    output logic                     prf_we1,
    output logic [5:0]               prf_waddr1,
    output logic [31:0]              prf_wdata1,
    output logic                     free_valid,
    output logic [5:0]               free_preg,
    input  logic                     free_ready,
    output logic                     commit_stall,
    output logic [CNT_WIDTH-1:0]     commit_count,
    output logic                     overflow_err
);
    localparam int PW = $clog2(FREE_Q_DEPTH);

    logic        v0, v1;
    logic [5:0]  old0, old1, rd0, rd1;
    logic [31:0] data0, data1;

    assign v0    = retire0[44];
    assign old0  = retire0[43:38];
    assign data0 = retire0[37:6];
    assign rd0   = retire0[5:0];
    assign v1    = retire1[44];
    assign old1  = retire1[43:38];
    assign data1 = retire1[37:6];
    assign rd1   = retire1[5:0];

    logic [5:0]    mem [FREE_Q_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count, count_next;
    logic [PW+1:0] space;
    logic          pop, req0, req1, has_a, has_b, drop;
    logic [5:0]    preg_a;

    assign free_valid = (count != '0);
    assign free_preg  = free_valid ? mem[rd_ptr] : 6'd0;

    // Slot A takes the oldest request; slot B only exists when both ports free a preg,
    // so running out of space always drops retire1 first.
    always_comb begin
        pop        = free_valid & free_ready;
        req0       = v0 && (old0 != 6'd0);
        req1       = v1 && (old1 != 6'd0);
        space      = (PW+2)'(FREE_Q_DEPTH) - {1'b0, count} + (PW+2)'(pop);
        has_a      = (req0 || req1) && (space != '0);
        has_b      = req0 && req1 && (space >= (PW+2)'(2));
        preg_a     = req0 ? old0 : old1;
        drop       = ((req0 || req1) && !has_a) || (req0 && req1 && !has_b);
        count_next = count + (PW+1)'(has_a) + (PW+1)'(has_b) - (PW+1)'(pop);
    end

    always_ff @(posedge clk) begin
        if (has_a) mem[wr_ptr] <= preg_a;
        if (has_b) mem[wr_ptr + PW'(1)] <= old1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            commit_stall <= 1'b0;
            overflow_err <= 1'b0;
            commit_count <= '0;
            prf_we0      <= 1'b0;
            prf_waddr0   <= 6'd0;
            prf_wdata0   <= 32'd0;
            prf_we1      <= 1'b0;
            prf_waddr1   <= 6'd0;
            prf_wdata1   <= 32'd0;
        end else begin
            wr_ptr       <= wr_ptr + PW'(has_a) + PW'(has_b);
            rd_ptr       <= rd_ptr + PW'(pop);
            count        <= count_next;
            commit_stall <= (count_next > (PW+1)'(FREE_Q_DEPTH - 2));
            if (drop) overflow_err <= 1'b1;
            commit_count <= commit_count + CNT_WIDTH'(v0) + CNT_WIDTH'(v1);
            // Younger packet owns the register when both target the same rd.
            prf_we0      <= v0 && !(v1 && (rd1 == rd0));
            prf_we1      <= v1;
            if (v0) begin
                prf_waddr0 <= rd0;
                prf_wdata0 <= data0;
            end
            if (v1) begin
                prf_waddr1 <= rd1;
                prf_wdata1 <= data1;
            end
        end
    end
endmodule

// File: tb/tb_commit_unit.sv
// tb/tb_commit_unit.sv - directed self-checking bench for commit_unit
module tb_commit_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [44:0] retire0, retire1;
    logic        prf_we0, prf_we1, free_valid, free_ready, commit_stall, overflow_err;
    logic [5:0]  prf_waddr0, prf_waddr1, free_preg;
    logic [31:0] prf_wdata0, prf_wdata1, commit_count;

    int n_checks = 0;
    int n_fail   = 0;

    commit_unit #(.FREE_Q_DEPTH(8), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .retire0(retire0), .retire1(retire1),
        .prf_we0(prf_we0), .prf_waddr0(prf_waddr0), .prf_wdata0(prf_wdata0),
        .prf_we1(prf_we1), .prf_waddr1(prf_waddr1), .prf_wdata1(prf_wdata1),
        .free_valid(free_valid), .free_preg(free_preg), .free_ready(free_ready),
        .commit_stall(commit_stall), .commit_count(commit_count),
        .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    function automatic logic [44:0] pkt(input logic v, input logic [5:0] old,
                                        input logic [31:0] d, input logic [5:0] rd);
        return {v, old, d, rd};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        retire0 = '0;
        retire1 = '0;
    endtask

    initial begin
        // T1: reset with valid packets presented
        rst_n = 1'b0; free_ready = 1'b0;
        retire0 = pkt(1, 6'd3, 32'd11, 6'd1);
        retire1 = pkt(1, 6'd4, 32'd22, 6'd2);
        tick(); tick();
        check("rst_we0", prf_we0, 0);
        check("rst_we1", prf_we1, 0);
        check("rst_waddr1", prf_waddr1, 0);
        check("rst_fvalid", free_valid, 0);
        check("rst_fpreg", free_preg, 0);
        check("rst_stall", commit_stall, 0);
        check("rst_cnt", commit_count, 0);
        check("rst_ovf", overflow_err, 0);
        idle();
        rst_n = 1'b1;
        tick();
        check("rel_fvalid", free_valid, 0);
        check("rel_cnt", commit_count, 0);

        // T2: dual retire
        free_ready = 1'b1;
        retire0 = pkt(1, 6'd5, 32'd7, 6'd12);
        retire1 = pkt(1, 6'd9, 32'd3, 6'd20);
        tick(); idle();
        check("t2_we0", prf_we0, 1);
        check("t2_waddr0", prf_waddr0, 12);
        check("t2_wdata0", prf_wdata0, 7);
        check("t2_we1", prf_we1, 1);
        check("t2_waddr1", prf_waddr1, 20);
        check("t2_wdata1", prf_wdata1, 3);
        check("t2_cnt", commit_count, 2);
        check("t2_free_a", free_preg, 5);
        tick();
        check("t2_we0_off", prf_we0, 0);
        check("t2_free_b", free_preg, 9);
        tick();
        check("t2_empty", free_valid, 0);

        // T3: p0 never freed, same rd -> younger wins
        retire0 = pkt(1, 6'd0, 32'd1, 6'd4);
        retire1 = pkt(1, 6'd6, 32'd2, 6'd4);
        tick(); idle();
        check("t3_we0", prf_we0, 0);
        check("t3_we1", prf_we1, 1);
        check("t3_waddr1", prf_waddr1, 4);
        check("t3_wdata1", prf_wdata1, 2);
        check("t3_free", free_preg, 6);
        tick();
        check("t3_empty", free_valid, 0);
        check("t3_cnt", commit_count, 4);

        // T4: back-pressure, order across pointer wrap
        free_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            retire0 = pkt(1, 6'(2*k+1), 32'd0, 6'(10+k));
            retire1 = pkt(1, 6'(2*k+2), 32'd0, 6'(20+k));
            tick();
            check($sformatf("t4_stall%0d", k), commit_stall, (k == 3) ? 1 : 0);
        end
        idle();
        free_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("t4_order%0d", i), free_preg, i);
            tick();
        end
        check("t4_empty", free_valid, 0);
        check("t4_stall_off", commit_stall, 0);
        check("t4_cnt", commit_count, 12);

        // T5: overflow at count=7, retire1 dropped
        free_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            retire0 = pkt(1, 6'(11+2*k), 32'd0, 6'd1);
            retire1 = pkt(k < 3, 6'(12+2*k), 32'd0, 6'd2);
            tick();
        end
        check("t5_no_ovf", overflow_err, 0);
        retire0 = pkt(1, 6'd21, 32'd0, 6'd1);
        retire1 = pkt(1, 6'd22, 32'd0, 6'd2);
        tick(); idle();
        check("t5_ovf", overflow_err, 1);
        check("t5_cnt", commit_count, 21);
        free_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t5_drain%0d", i), free_preg, (i < 7) ? 11 + i : 21);
            tick();
        end
        check("t5_empty", free_valid, 0);
        check("t5_ovf_sticky", overflow_err, 1);
        rst_n = 1'b0; #1;
        check("t5_ovf_clr", overflow_err, 0);
        rst_n = 1'b1;
        tick();

        // T6: async reset mid-drain with count=5
        free_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            retire0 = pkt(1, 6'(31+2*k), 32'd0, 6'd1);
            retire1 = pkt(k < 2, 6'(32+2*k), 32'd0, 6'd2);
            tick();
        end
        idle();
        check("t6_pre", free_preg, 31);
        #2;
        rst_n = 1'b0; #1;
        check("t6_fvalid_drop", free_valid, 0);
        check("t6_cnt_clr", commit_count, 0);
        #1 rst_n = 1'b1;
        tick();
        check("t6_empty", free_valid, 0);
        retire0 = pkt(1, 6'd40, 32'h55, 6'd0);
        tick(); idle();
        check("t6_rd0_we", prf_we0, 1);
        check("t6_rd0_addr", prf_waddr0, 0);
        check("t6_fresh", free_preg, 40);
        check("t6_cnt", commit_count, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
